// File: rtl/pcs_rx_deser_align_pkg.sv
// pcs_pkg: shared definitions for the 1G PCS receive deserializer/aligner.
//
// Code-group convention: a 10-bit group is held in a logic [9:0] vector whose
// index 0 is the first bit on the wire (bit "a"). The spec-style literals below
// are written in wire order (leftmost character = bit a). wire_order() turns
// them into index order, so K28_5_RDN[0] is bit a.
//
// Contents:
//   rx_sync_state_e  - alignment FSM states (HUNT, LOCKED)
//   wire_order()     - wire-order literal -> index-ordered vector
//   K28_5_RDN/RDP    - K28.5 code groups, index ordered
//   COMMA_P/COMMA_N  - 7-bit comma patterns (bits a..g), index ordered
//   is_comma()       - true when bits 0..6 of a group hold either comma
package pcs_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_sync_state_e;

  function automatic logic [9:0] wire_order(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) begin
      r[i] = v[9-i];
    end
    return r;
  endfunction

  // Wire order a..j: 0011111010 and 1100000101.
  localparam logic [9:0] K28_5_RDN = wire_order(10'b0011111010);
  localparam logic [9:0] K28_5_RDP = wire_order(10'b1100000101);

  // Bits a..g of the two K28.5 disparities: 0011111 and 1100000.
  localparam logic [6:0] COMMA_P = K28_5_RDN[6:0];
  localparam logic [6:0] COMMA_N = K28_5_RDP[6:0];

  function automatic logic is_comma(input logic [9:0] grp);
    return (grp[6:0] == COMMA_P) || (grp[6:0] == COMMA_N);
  endfunction

endpackage

// File: rtl/pcs_rx_deser_align_comma_detect.sv
// pcs_comma_detect: combinational comma compare on the receive window.
//
// Optional macro PCS_RX_DIFF_CHECK_EN adds the diff_bits input; any flagged
// bit in the window disqualifies the comma.
//
// Ports:
//   window     in  10  receive window, index 0 = oldest (first) bit
//   diff_bits  in  10  per-bit differential error flags (macro only)
//   comma      out  1  window bits 0..6 hold a valid comma
module pcs_comma_detect
  import pcs_pkg::*;
(
  input  logic [9:0] window,
`ifdef PCS_RX_DIFF_CHECK_EN
  input  logic [9:0] diff_bits,
`endif
  output logic       comma
);

  always_comb begin
`ifdef PCS_RX_DIFF_CHECK_EN
    comma = is_comma(window) && (diff_bits == '0);
`else
    comma = is_comma(window);
`endif
  end

endmodule

// File: rtl/pcs_rx_deser_align.sv
// pcs_rx_deser_align: 1G PCS receive deserializer with comma alignment.
//
// One serial bit is shifted in per clk (newest bit at window index 9). A
// HUNT/LOCKED FSM finds the comma phase, then emits one aligned 10-bit group
// per 10 clks with a one-cycle rx_valid strobe, one clk after the group's
// last bit was sampled. A comma persistently seen at another phase while
// locked re-phases the aligner and pulses realign.
//
// Optional macro PCS_RX_DIFF_CHECK_EN: adds diff_err and rejects commas in
// groups that contain a bit with rxp == rxn.
//
// Ports:
//   clk            in   1  bit clock
//   rst_n          in   1  asynchronous active-low reset
//   rxp            in   1  serial data, positive leg
//   rxn            in   1  serial data, negative leg (macro only)
//   signal_detect  in   1  PMD signal present; low forces HUNT
//   rx_code_group  out 10  aligned group, index 0 = first received bit
//   rx_valid       out  1  one-cycle strobe for rx_code_group
//   rx_comma       out  1  group bits 0..6 are a comma (with rx_valid)
//   sync_locked    out  1  alignment acquired
//   realign        out  1  one-cycle pulse on a lock phase change
//   diff_err       out  1  sampled bit had rxp == rxn (macro only)
module pcs_rx_deser_align
  import pcs_pkg::*;
#(
  parameter int MISALIGN_MAX = 3,
  parameter int LOCK_COMMAS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxp,
  input  logic       rxn,
  input  logic       signal_detect,
  output logic [9:0] rx_code_group,
  output logic       rx_valid,
  output logic       rx_comma,
  output logic       sync_locked,
`ifdef PCS_RX_DIFF_CHECK_EN
  output logic       diff_err,
`endif
  output logic       realign
);

  localparam int MCW = $clog2(LOCK_COMMAS + 1);
  localparam int XCW = $clog2(MISALIGN_MAX + 1);
  localparam logic [MCW-1:0] LOCK_N = MCW'(LOCK_COMMAS);
  localparam logic [XCW-1:0] MIS_N  = XCW'(MISALIGN_MAX);

  logic [9:0]     win;
  logic [3:0]     bit_cnt;
  rx_sync_state_e state;
  logic [MCW-1:0] match_cnt;
  logic [XCW-1:0] mis_cnt;

  logic           comma;
  logic           boundary;
  logic [3:0]     cnt_nxt;
  logic [MCW-1:0] match_nxt;
  logic [XCW-1:0] mis_nxt;

`ifdef PCS_RX_DIFF_CHECK_EN
  logic [9:0] diff_win;

  // Per-bit error flags travel with the data window so each group knows
  // whether it contains a bad bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_win <= '0;
      diff_err <= 1'b0;
    end else begin
      diff_win <= {rxp == rxn, diff_win[9:1]};
      diff_err <= (rxp == rxn);
    end
  end

  pcs_comma_detect u_comma_detect (
    .window    (win),
    .diff_bits (diff_win),
    .comma     (comma)
  );
`else
  logic unused_rxn;
  assign unused_rxn = rxn;

  pcs_comma_detect u_comma_detect (
    .window (win),
    .comma  (comma)
  );
`endif

  always_comb begin
    boundary  = (bit_cnt == 4'd9);
    cnt_nxt   = boundary ? 4'd0 : bit_cnt + 4'd1;
    // In HUNT a comma on the running boundary repeats the candidate phase;
    // anywhere else it starts a fresh candidate.
    match_nxt = boundary ? match_cnt + MCW'(1) : MCW'(1);
    mis_nxt   = mis_cnt + XCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win           <= '0;
      bit_cnt       <= 4'd0;
      state         <= HUNT;
      match_cnt     <= '0;
      mis_cnt       <= '0;
      rx_code_group <= '0;
      rx_valid      <= 1'b0;
      rx_comma      <= 1'b0;
      sync_locked   <= 1'b0;
      realign       <= 1'b0;
    end else begin
      // The window keeps shifting in every state, including signal loss.
      win      <= {rxp, win[9:1]};
      rx_valid <= 1'b0;
      rx_comma <= 1'b0;
      realign  <= 1'b0;

      if (!signal_detect) begin
        // Drop the partial group and restart acquisition from scratch.
        state       <= HUNT;
        sync_locked <= 1'b0;
        bit_cnt     <= 4'd0;
        match_cnt   <= '0;
        mis_cnt     <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (comma) begin
              // Comma ends a group here: the counter restarts on this phase.
              bit_cnt <= 4'd0;
              if (match_nxt == LOCK_N) begin
                state         <= LOCKED;
                sync_locked   <= 1'b1;
                rx_valid      <= 1'b1;
                rx_comma      <= 1'b1;
                rx_code_group <= win;
                match_cnt     <= '0;
                mis_cnt       <= '0;
              end else begin
                match_cnt <= match_nxt;
              end
            end else begin
              bit_cnt <= cnt_nxt;
            end
          end

          LOCKED: begin
            if (boundary) begin
              bit_cnt       <= 4'd0;
              rx_valid      <= 1'b1;
              rx_comma      <= comma;
              rx_code_group <= win;
              if (comma) begin
                mis_cnt <= '0;
              end
            end else if (comma) begin
              if (mis_nxt == MIS_N) begin
                // Adopt the new phase; the partial group at the old phase
                // is abandoned by restarting the counter here.
                bit_cnt       <= 4'd0;
                rx_valid      <= 1'b1;
                rx_comma      <= 1'b1;
                rx_code_group <= win;
                realign       <= 1'b1;
                mis_cnt       <= '0;
              end else begin
                mis_cnt <= mis_nxt;
                bit_cnt <= cnt_nxt;
              end
            end else begin
              bit_cnt <= cnt_nxt;
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcs_rx_deser_align.sv
// tb_pcs_rx_deser_align: directed bench for pcs_rx_deser_align with a
// behavioural alignment model compared every cycle, plus literal checks of
// strobe timing and contents at hand-computed edges.
module tb_pcs_rx_deser_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxp = 1'b0;
  logic       rxn = 1'b1;
  logic       signal_detect = 1'b1;
  logic [9:0] rx_code_group;
  logic       rx_valid, rx_comma, sync_locked, realign;
`ifdef PCS_RX_DIFF_CHECK_EN
  logic       diff_err;
`endif

  always #5 clk = ~clk;

  pcs_rx_deser_align #(.MISALIGN_MAX(3), .LOCK_COMMAS(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxp           (rxp),
    .rxn           (rxn),
    .signal_detect (signal_detect),
    .rx_code_group (rx_code_group),
    .rx_valid      (rx_valid),
    .rx_comma      (rx_comma),
    .sync_locked   (sync_locked),
`ifdef PCS_RX_DIFF_CHECK_EN
    .diff_err      (diff_err),
`endif
    .realign       (realign)
  );

  // Groups written in wire order, leftmost character = first bit sent.
  localparam logic [9:0] W_RDN  = 10'b0011111010;
  localparam logic [9:0] W_RDP  = 10'b1100000101;
  localparam logic [9:0] W_D215 = 10'b1010101010;
  localparam int MIS_MAX = 3;
  localparam int LOCK_N  = 1;
  localparam int NREC    = 1024;

  int checks = 0;
  int failures = 0;

  // Per-edge record of what the DUT produced, indexed by edge number.
  logic       v_at  [NREC];
  logic       c_at  [NREC];
  logic       lk_at [NREC];
  logic       ra_at [NREC];
  logic       d_at  [NREC];
  logic [9:0] g_at  [NREC];

  function automatic logic [9:0] idx10(input logic [9:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic hist[$];
  logic dhist[$];
  int   edge_n = 0;
  int   m_next_b, m_match, m_mis;
  bit   m_locked, m_pending;

  // A comma is a run "aa" followed by five copies of the opposite value.
  function automatic bit m_comma(input logic [9:0] w, input logic [9:0] dw);
    bit run = 1'b1;
    for (int i = 3; i <= 6; i++) if (w[i] != w[2]) run = 1'b0;
    return run && (w[0] == w[1]) && (w[1] != w[2]) && (dw == 10'd0);
  endfunction

  always @(posedge clk) begin
    logic [9:0] w, dw, e_grp;
    logic [14:0] act, exp;
    bit cm, e_valid, e_comma, e_realign, e_diff;
    int e;
    if (!rst_n) begin
      hist = {};
      dhist = {};
      for (int i = 0; i < 10; i++) begin hist.push_back(1'b0); dhist.push_back(1'b0); end
      m_locked = 0; m_match = 0; m_mis = 0; m_pending = 1;
      #1;
      chk("reset_outputs", {rx_valid, rx_comma, realign, sync_locked, rx_code_group}, 32'd0);
    end else begin
      e = edge_n;
      // First edge after reset release counts as bit 0 of a group.
      if (m_pending) begin m_next_b = e + 9; m_pending = 0; end
      for (int i = 0; i < 10; i++) begin w[i] = hist[i]; dw[i] = dhist[i]; end
      cm = m_comma(w, dw);
      e_valid = 0; e_comma = 0; e_realign = 0; e_grp = 10'd0;
      if (!signal_detect) begin
        m_locked = 0; m_match = 0; m_mis = 0; m_next_b = e + 10;
      end else if (!m_locked) begin
        if (cm) begin
          m_match = (e == m_next_b) ? m_match + 1 : 1;
          m_next_b = e + 10;
          if (m_match >= LOCK_N) begin
            m_locked = 1; m_match = 0; m_mis = 0;
            e_valid = 1; e_comma = 1; e_grp = w;
          end
        end else if (e == m_next_b) begin
          m_next_b = e + 10;
        end
      end else begin
        if (e == m_next_b) begin
          e_valid = 1; e_comma = cm; e_grp = w;
          if (cm) m_mis = 0;
          m_next_b = e + 10;
        end else if (cm) begin
          m_mis++;
          if (m_mis == MIS_MAX) begin
            e_valid = 1; e_comma = 1; e_realign = 1; e_grp = w;
            m_mis = 0; m_next_b = e + 10;
          end
        end
      end
      e_diff = (rxp === rxn);
      hist.push_back(rxp);  void'(hist.pop_front());
      dhist.push_back(rxp === rxn); void'(dhist.pop_front());
      #1;
`ifdef PCS_RX_DIFF_CHECK_EN
      act = {rx_valid, sync_locked, realign, rx_valid & rx_comma, diff_err,
             rx_valid ? rx_code_group : 10'd0};
      exp = {e_valid, m_locked, e_realign, e_comma, e_diff, e_grp};
`else
      act = {rx_valid, sync_locked, realign, rx_valid & rx_comma, 1'b0,
             rx_valid ? rx_code_group : 10'd0};
      exp = {e_valid, m_locked, e_realign, e_comma, 1'b0, e_grp};
`endif
      if (act !== exp)
        $display("edge %0d: valid/lock/realign/comma/diff/group", e);
      chk("cycle_model", {17'd0, act}, {17'd0, exp});
      if (e < NREC) begin
        v_at[e] = rx_valid; c_at[e] = rx_comma; lk_at[e] = sync_locked;
        ra_at[e] = realign; g_at[e] = rx_code_group;
`ifdef PCS_RX_DIFF_CHECK_EN
        d_at[e] = diff_err;
`else
        d_at[e] = 1'b0;
`endif
      end
      edge_n++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b);
    rxp = b;
    rxn = ~b;
    @(negedge clk);
  endtask

  task automatic send_grp(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) send_bit(s[i]);
  endtask

  function automatic int count_v(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (v_at[i]) n++;
    return n;
  endfunction

  function automatic int count_ra(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (ra_at[i]) n++;
    return n;
  endfunction

  function automatic int count_lk(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (lk_at[i]) n++;
    return n;
  endfunction

  initial begin
    for (int i = 0; i < NREC; i++) begin
      v_at[i] = 0; c_at[i] = 0; lk_at[i] = 0; ra_at[i] = 0; d_at[i] = 0; g_at[i] = '0;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(i[0]);   // toggling in reset
    rst_n = 1'b1;
    for (int g = 0; g < 20; g++) send_grp(W_D215);   // edges 0..199, no comma
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);  // junk 200..202
    send_grp(W_RDN);                                  // 203..212
    for (int g = 0; g < 5; g++) send_grp(W_D215);     // 213..262
    send_bit(1'b0);                                   // slip bit 263
    for (int g = 0; g < 4; g++) begin                 // 264..343
      send_grp(W_RDP);
      send_grp(W_D215);
    end
    for (int i = 0; i < 20; i++) begin                // 344..363, loss 349..353
      signal_detect = !(i >= 5 && i < 10);
      send_bit(W_D215[9 - (i % 10)]);
    end
    signal_detect = 1'b1;
    send_grp(W_RDN);                                  // 364..373
    send_grp(W_D215); send_grp(W_D215);               // 374..393
    for (int i = 0; i < 4; i++) send_bit(W_D215[9 - i]);  // 394..397 partial
    #2 rst_n = 1'b0;
    #1 chk("async_reset_clear", {rx_valid, rx_comma, realign, sync_locked, rx_code_group}, 32'd0);
    for (int i = 0; i < 3; i++) send_bit(i[0]);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) send_grp(W_D215);     // 398..427
`ifdef PCS_RX_DIFF_CHECK_EN
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);  // 428..430
    for (int i = 0; i < 10; i++) begin                // comma 431..440, bad bit at 435
      rxp = W_RDN[9 - i];
      rxn = (i == 4) ? W_RDN[9 - i] : ~W_RDN[9 - i];
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) send_grp(W_D215);     // 441..470
`endif
    send_grp(W_D215);
    @(negedge clk);

    chk("no_strobe_before_comma", count_v(0, 212), 0);
    chk("no_lock_before_comma", count_lk(0, 212), 0);
    chk("lock_strobe_213", {v_at[213], c_at[213], g_at[213]}, {1'b1, 1'b1, idx10(W_RDN)});
    for (int k = 1; k <= 4; k++)
      chk($sformatf("d215_strobe_%0d", 213 + 10 * k),
          {v_at[213 + 10 * k], c_at[213 + 10 * k], g_at[213 + 10 * k]},
          {1'b1, 1'b0, idx10(W_D215)});
    chk("strobes_213_253", count_v(213, 253), 5);
    chk("locked_253", lk_at[253], 1);
    chk("realign_count", count_ra(0, 427), 1);
    chk("realign_314", {ra_at[314], v_at[314], c_at[314], g_at[314]},
        {1'b1, 1'b1, 1'b1, idx10(W_RDP)});
    chk("post_realign_324", {v_at[324], c_at[324], g_at[324]}, {1'b1, 1'b0, idx10(W_D215)});
    chk("post_realign_334", {v_at[334], c_at[334], g_at[334]}, {1'b1, 1'b1, idx10(W_RDP)});
    chk("lock_drop_349", {lk_at[348], lk_at[349]}, 2'b10);
    chk("no_strobe_in_loss", count_v(345, 373), 0);
    chk("relock_374", {v_at[374], c_at[374], lk_at[374]}, 3'b111);
    chk("quiet_after_reset", count_v(398, 427) + count_lk(398, 427), 0);
`ifdef PCS_RX_DIFF_CHECK_EN
    chk("diff_pulse_435", {d_at[434], d_at[435], d_at[436]}, 3'b010);
    chk("diff_blocks_lock", count_lk(428, 471), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
